tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive end of a 4-slot time-division link whose transmit end is the team's 4:1 mux.
- Takes a serial stream of samples, one per valid beat, with a frame-sync marker on slot 0.
- Steers each sample into its channel holding register and emits per-channel strobes.
- Sits after the mux/serialiser in the lab datapath. Provides a checkable round trip: A,B,C,D → mux → tdm_demux → Y0..Y3.

Parameters:
- WIDTH, 1, sample width in bits per channel.
- N_CH, 4, number of slots per frame; must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  incoming sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the slot-0 sample.
- ch_out  output  N_CH*WIDTH  channel holding registers; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_valid  output  N_CH  one-cycle strobe; bit k = ch_out channel k was written last cycle.
- frame_done  output  1  one-cycle strobe when a complete frame (slots 0..N_CH-1 in order) has landed.
- sel  output  clog2(N_CH)  slot index the next valid beat will be written to.
- locked  output  1  high while in state LOCKED.
- sync_err  output  1  one-cycle strobe on misplaced frame_sync (only with the optional feature; tied 0 otherwise).

Behaviour:
- Clock and reset:
  - Single clock domain, all outputs registered.
  - Reset is synchronous and active-high.
- Reset values:
  - ch_out = 0, ch_valid = 0, frame_done = 0, sel = 0, locked = 0, sync_err = 0.
  - State HUNT.
- FSM states: HUNT and LOCKED.
- HUNT:
  - Beats without frame_sync are discarded; no output changes.
  - din_valid && frame_sync: write din to channel 0, set sel = 1, go to LOCKED.
- LOCKED:
  - Each din_valid beat writes din to channel sel.
  - sel then increments modulo N_CH (N_CH-1 wraps to 0).
- Latency:
  - ch_out[sel] and ch_valid[sel] are updated/asserted on the clock edge that samples the beat (visible the following cycle).
  - frame_done asserts together with ch_valid[N_CH-1], and only if slot 0 of that frame was entered via frame_sync or a clean wrap.
- din_valid low: holding registers keep their values; all strobes 0; sel unchanged.
- frame_sync without din_valid: ignored in every state.
- frame_sync with a valid beat at sel = 0 in LOCKED: normal beat.
- Exactly one ch_valid bit is high per accepted beat; never more than one.
- Reset during a frame: on the next edge, all outputs return to reset values and the state is HUNT. A partial frame is discarded and produces no frame_done.
- Reset has priority over any simultaneous din_valid/frame_sync.

Optional Feature:
- Macro: TDM_SYNC_CHECK_EN.
- Defined, frame_sync with din_valid in LOCKED at sel ≠ 0:
  - sync_err pulses for one cycle.
  - The beat is written to channel 0 and sel becomes 1 (resync).
  - frame_done is suppressed until the next full, in-order frame completes.
- Undefined:
  - frame_sync is ignored in LOCKED; the beat is written to channel sel as usual.
  - sync_err is tied to 0.

Decomposition:
- Shared package (tdm_pkg / tdm_defs include) holds:
  - State encodings ST_HUNT = 1'b0, ST_LOCKED = 1'b1.
  - Default N_CH = 4.
  - SLOT_W = clog2(N_CH).
- The same package is reused by a future tdm_mux transmitter.
- One sub-module, tdm_slot_counter:
  - Modulo-N_CH counter with synchronous clear, load-to-1 (sync/resync) and increment-enable.
  - Outputs the count and a wrap flag.

Test Plan:
- Reset then lock: rst high 2 cycles → all outputs 0, locked = 0. Beat din=4'h3 with no sync → ignored, locked = 0.
- Full frame, WIDTH=4: beats 4'hA (sync), 4'hB, 4'hC, 4'hD on consecutive cycles.
  - Required: ch_out = {D,C,B,A}.
  - ch_valid sequence 0001, 0010, 0100, 1000.
  - frame_done high only with 1000.
  - sel goes 1, 2, 3, 0.
- Gapped beats: din_valid low 3 cycles between slots 1 and 2 → sel holds at 2, ch_out unchanged, no strobes, frame completes normally.
- Misplaced sync (TDM_SYNC_CHECK_EN) at sel=2 with din=4'h7:
  - Required: sync_err = 1, ch_out[0] = 7, sel = 1, no frame_done at the following slot-3 beat.
  - Macro off: 4'h7 lands in channel 2 and sync_err stays 0.
- Reset mid-frame after 2 beats → next cycle ch_out = 0, locked = 0, no frame_done. A new sync frame then completes correctly.
- Back-to-back frames (8 beats, sync on beats 0 and 4) → frame_done pulses exactly twice and sync_err never fires.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link (demux now, tdm_mux transmitter later).
// Latency: n/a. Backpressure: n/a.
package tdm_pkg;

    localparam int DEF_N_CH = 4;

    localparam logic ST_HUNT   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    function automatic int slot_w(input int n_ch);
        return $clog2(n_ch);
    endfunction

    localparam int SLOT_W = slot_w(DEF_N_CH);

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter with sync clear, load-to-1 (sync/resync) and increment enable.
// Latency: count registered, wrap_o combinational from count and inc_i. Backpressure: none.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int SW   = slot_w(DEF_N_CH)
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          load1_i,
    input  logic          inc_i,
    output logic [SW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = ONE;
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: steers one sample per valid beat into per-channel holding registers.
// Latency: 1 cycle, all outputs registered. Backpressure: none; optional TDM_SYNC_CHECK_EN resync.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_CH  = DEF_N_CH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       frame_sync,
    output logic [N_CH*WIDTH-1:0]      ch_out,
    output logic [N_CH-1:0]            ch_valid,
    output logic                       frame_done,
    output logic [$clog2(N_CH)-1:0]    sel,
    output logic                       locked,
    output logic                       sync_err
);

    localparam int SW = slot_w(N_CH);

    logic                        state_q, state_d;
    logic [N_CH-1:0][WIDTH-1:0]  ch_q;
    logic [N_CH-1:0]             ch_valid_q, ch_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        sync_err_q;
    logic                        frame_ok_q, frame_ok_d;

    logic                        hunt_sync;
    logic                        locked_beat;
    logic                        resync;
    logic                        normal_beat;
    logic                        wr_en;
    logic [SW-1:0]               wr_idx;
    logic [SW-1:0]               slot;
    logic                        slot_wrap;

    assign hunt_sync   = (state_q == ST_HUNT) && din_valid && frame_sync;
    assign locked_beat = (state_q == ST_LOCKED) && din_valid;

`ifdef TDM_SYNC_CHECK_EN
    assign resync = locked_beat && frame_sync && (slot != '0);
`else
    assign resync = 1'b0;
`endif

    assign normal_beat = locked_beat && !resync;
    assign wr_en       = hunt_sync || locked_beat;
    assign wr_idx      = (hunt_sync || resync) ? '0 : slot;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk_i   (clk),
        .clr_i   (rst),
        .load1_i (hunt_sync || resync),
        .inc_i   (normal_beat),
        .cnt_o   (slot),
        .wrap_o  (slot_wrap)
    );

    // A frame only counts as complete if its slot 0 came from a sync in HUNT or a clean wrap.
    always_comb begin
        state_d      = state_q;
        frame_ok_d   = frame_ok_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        if (hunt_sync) begin
            state_d    = ST_LOCKED;
            frame_ok_d = 1'b1;
        end else if (resync) begin
            frame_ok_d = 1'b0;
        end else if (normal_beat && (slot == '0)) begin
            frame_ok_d = 1'b1;
        end
        if (wr_en) begin
            ch_valid_d[wr_idx] = 1'b1;
        end
        frame_done_d = normal_beat && slot_wrap && frame_ok_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            ch_q         <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= resync;
            frame_ok_q   <= frame_ok_d;
            if (wr_en) begin
                ch_q[wr_idx] <= din;
            end
        end
    end

    assign ch_out     = ch_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sel        = slot;
    assign locked     = (state_q == ST_LOCKED);
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (WIDTH=4, N_CH=4); follows TDM_SYNC_CHECK_EN when defined.
module tb_tdm_demux;

    localparam int WIDTH = 4;
    localparam int N_CH  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [15:0]      ch_out;
    logic [3:0]       ch_valid;
    logic             frame_done;
    logic [1:0]       sel;
    logic             locked;
    logic             sync_err;

    tdm_demux #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sel        (sel),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        fs;
        logic [3:0]  din;
        logic [15:0] e_ch;
        logic [3:0]  e_cv;
        logic        e_fd;
        logic [1:0]  e_sel;
        logic        e_lk;
        logic        e_se;
    } vec_t;

    typedef logic [24:0] obs_t;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic v, input logic f, input logic [3:0] d,
                       input logic [15:0] ch, input logic [3:0] cv, input logic fd,
                       input logic [1:0] s, input logic lk, input logic se);
        vec_t t;
        t = '{rst: r, vld: v, fs: f, din: d, e_ch: ch, e_cv: cv, e_fd: fd,
              e_sel: s, e_lk: lk, e_se: se};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drive one beat, push its expectation, sample after the edge and compare against the queue head.
    task automatic step(input int idx, input vec_t t);
        obs_t e, a;
        rst        = t.rst;
        din_valid  = t.vld;
        frame_sync = t.fs;
        din        = t.din;
        exp_q.push_back({t.e_ch, t.e_cv, t.e_fd, t.e_sel, t.e_lk, t.e_se});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = {ch_out, ch_valid, frame_done, sel, locked, sync_err};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL vec%0d: got ch=%h cv=%b fd=%b sel=%0d lk=%b se=%b, required ch=%h cv=%b fd=%b sel=%0d lk=%b se=%b",
                     idx, a[24:9], a[8:5], a[4], a[3:2], a[1], a[0],
                     e[24:9], e[8:5], e[4], e[3:2], e[1], e[0]);
        end
    endtask

    initial begin
        int fd_cnt;
        int se_cnt;

        //   rst v  f  din    ch_out    cv      fd  sel  lk  se
        add(1, 0, 0, 4'h0, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(1, 0, 0, 4'h0, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 0, 4'h3, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 1, 4'hA, 16'h000A, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'hB, 16'h00BA, 4'b0010, 0, 2'd2, 1, 0);
        add(0, 1, 0, 4'hC, 16'h0CBA, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'hD, 16'hDCBA, 4'b1000, 1, 2'd0, 1, 0);
        add(0, 1, 0, 4'h1, 16'hDCB1, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'h2, 16'hDC21, 4'b0010, 0, 2'd2, 1, 0);
        add(0, 0, 1, 4'hF, 16'hDC21, 4'b0000, 0, 2'd2, 1, 0);
        add(0, 0, 0, 4'hF, 16'hDC21, 4'b0000, 0, 2'd2, 1, 0);
        add(0, 0, 1, 4'hE, 16'hDC21, 4'b0000, 0, 2'd2, 1, 0);
        add(0, 1, 0, 4'h3, 16'hD321, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'h4, 16'h4321, 4'b1000, 1, 2'd0, 1, 0);
        add(0, 1, 0, 4'h5, 16'h4325, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'h6, 16'h4365, 4'b0010, 0, 2'd2, 1, 0);
`ifdef TDM_SYNC_CHECK_EN
        add(0, 1, 1, 4'h7, 16'h4367, 4'b0001, 0, 2'd1, 1, 1);
        add(0, 1, 0, 4'h8, 16'h4387, 4'b0010, 0, 2'd2, 1, 0);
        add(0, 1, 0, 4'h9, 16'h4987, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'hE, 16'hE987, 4'b1000, 0, 2'd0, 1, 0);
        add(0, 1, 0, 4'h1, 16'hE981, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'h2, 16'hE921, 4'b0010, 0, 2'd2, 1, 0);
        add(0, 1, 0, 4'h3, 16'hE321, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'h4, 16'h4321, 4'b1000, 1, 2'd0, 1, 0);
`else
        add(0, 1, 1, 4'h7, 16'h4765, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'h8, 16'h8765, 4'b1000, 1, 2'd0, 1, 0);
        add(0, 1, 0, 4'h9, 16'h8769, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'hE, 16'h87E9, 4'b0010, 0, 2'd2, 1, 0);
`endif
        add(1, 1, 1, 4'h1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 0, 4'h2, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 1, 4'h1, 16'h0001, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'h2, 16'h0021, 4'b0010, 0, 2'd2, 1, 0);
        add(1, 1, 0, 4'h3, 16'h0000, 4'b0000, 0, 2'd0, 0, 0);
        add(0, 1, 1, 4'h5, 16'h0005, 4'b0001, 0, 2'd1, 1, 0);
        add(0, 1, 0, 4'h6, 16'h0065, 4'b0010, 0, 2'd2, 1, 0);
        add(0, 1, 0, 4'h7, 16'h0765, 4'b0100, 0, 2'd3, 1, 0);
        add(0, 1, 0, 4'h8, 16'h8765, 4'b1000, 1, 2'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end
        check("queue_drained", exp_q.size(), 0);

        // Back-to-back frames from a fresh reset, sync on beats 0 and 4.
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fd_cnt = 0;
        se_cnt = 0;
        for (int b = 0; b < 8; b++) begin
            din_valid  = 1'b1;
            frame_sync = (b % 4 == 0);
            din        = 4'(b + 1);
            @(posedge clk);
            #1;
            if (frame_done) fd_cnt++;
            if (sync_err)   se_cnt++;
            if ($countones(ch_valid) != 1) begin
                check("b2b_onehot", int'(ch_valid), 1 << (b % 4));
            end
        end
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (sync_err)   se_cnt++;
        check("b2b_frame_done_count", fd_cnt, 2);
        check("b2b_sync_err_count", se_cnt, 0);
        check("b2b_ch_out", int'(ch_out), 32'h8765);
        check("b2b_idle_strobes", int'(ch_valid), 0);
        check("b2b_sel", int'(sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
